// File: rtl/panel_ctrl.sv
// ---------------------------------------------------------------------------
// panel_ctrl -- front-panel controller for the TOY machine.
//
// Debounces the five raw panel buttons into single-cycle press events, owns
// the panel side of the main-memory rw port (load = write switches, look =
// read), and issues run/step/stop pulses to the core.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   btn_*_i                  raw buttons (load, look, step, run, stop)
//   sw_addr_i, sw_data_i     address / data switches (quasi-static)
//   core_running_i           core is executing
//   core_run_o/step_o/stop_o one-cycle control pulses to the core
//   pc_wen_o, pc_o           one-cycle PC load strobe and value
//   mem_val_o .. mem_rdy_i   memory request port
//                            (valid/ready: a request is offered by holding
//                            mem_val_o high with addr/wen/wdata stable; it
//                            completes on the first cycle mem_rdy_i is
//                            sampled high, and mem_rdata_i is taken then)
//   disp_addr_o/disp_data_o  address/data of the last completed access
//   led_inwait_o             memory access in progress (also exposes state)
//   led_ready_o              idle and core not running
// ---------------------------------------------------------------------------
module panel_ctrl #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_INC        = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              btn_load_i,
    input  logic              btn_look_i,
    input  logic              btn_step_i,
    input  logic              btn_run_i,
    input  logic              btn_stop_i,
    input  logic [ADDR_W-1:0] sw_addr_i,
    input  logic [DATA_W-1:0] sw_data_i,
    input  logic              core_running_i,
    output logic              core_run_o,
    output logic              core_step_o,
    output logic              core_stop_o,
    output logic              pc_wen_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              mem_val_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rdy_i,
    output logic [ADDR_W-1:0] disp_addr_o,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              led_inwait_o,
    output logic              led_ready_o
);

    localparam int B_LOAD = 0;
    localparam int B_LOOK = 1;
    localparam int B_STEP = 2;
    localparam int B_RUN  = 3;
    localparam int B_STOP = 4;
    localparam int NB     = 5;
    localparam int CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state;
    logic [NB-1:0]     sync1;
    logic [NB-1:0]     sync2;
    logic [NB-1:0]     level;
    logic [NB-1:0]     level_d;
    logic [CW-1:0]     cnt [NB];
    logic [NB-1:0]     press;

    logic [ADDR_W-1:0] addr_q;      // address of last completed access
    logic [ADDR_W-1:0] snap_q;      // sw_addr_i seen at the event of that access
    logic [ADDR_W-1:0] snap_evt;    // sw_addr_i captured at the pending event
    logic              have_prev;   // at least one access has completed
    logic              auto_hit;
    logic [ADDR_W-1:0] target;

    // ---------------- debounce ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1   <= {btn_stop_i, btn_run_i, btn_step_i, btn_look_i, btn_load_i};
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != level[i]) begin
                    // Accept the new level on the DEBOUNCE_CYCLES-th differing cycle.
                    if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        level[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press = level & ~level_d;

    // Repeating an access without touching the address switches walks forward.
    assign auto_hit = (AUTO_INC != 0) && have_prev && (sw_addr_i == snap_q);
    assign target   = auto_hit ? (addr_q + ADDR_W'(1)) : sw_addr_i;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            core_run_o  <= 1'b0;
            core_step_o <= 1'b0;
            core_stop_o <= 1'b0;
            pc_wen_o    <= 1'b0;
            pc_o        <= '0;
            mem_val_o   <= 1'b0;
            mem_wen_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            disp_addr_o <= '0;
            disp_data_o <= '0;
            addr_q      <= '0;
            snap_q      <= '0;
            snap_evt    <= '0;
            have_prev   <= 1'b0;
        end else begin
            core_run_o  <= 1'b0;
            core_step_o <= 1'b0;
            core_stop_o <= 1'b0;
            pc_wen_o    <= 1'b0;

            // While the core runs, stop is the only button that means anything.
            if (core_running_i && press[B_STOP]) begin
                core_stop_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!core_running_i) begin
                        if (press[B_RUN]) begin
                            core_run_o <= 1'b1;
                        end else if (press[B_STEP]) begin
                            core_step_o <= 1'b1;
                        end else if (press[B_LOAD] || press[B_LOOK]) begin
                            state       <= REQ;
                            mem_val_o   <= 1'b1;
                            mem_wen_o   <= press[B_LOAD];
                            mem_addr_o  <= target;
                            mem_wdata_o <= sw_data_i;
                            snap_evt    <= sw_addr_i;
                        end
                    end
                end
                REQ: begin
                    if (mem_rdy_i) begin
                        state       <= IDLE;
                        mem_val_o   <= 1'b0;
                        addr_q      <= mem_addr_o;
                        snap_q      <= snap_evt;
                        have_prev   <= 1'b1;
                        disp_addr_o <= mem_addr_o;
                        disp_data_o <= mem_wen_o ? mem_wdata_o : mem_rdata_i;
                        pc_wen_o    <= 1'b1;
                        pc_o        <= mem_addr_o;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign led_inwait_o = (state == REQ);
    assign led_ready_o  = (state == IDLE) & ~core_running_i;

endmodule

// File: tb/tb_panel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_panel_ctrl -- scoreboard bench for panel_ctrl (default parameters).
// Stimulus pushes expected output events into exp_q; a monitor turns each
// observed DUT output event into the same encoding and compares in order.
// A memory responder answers requests after rdy_lat wait cycles with
// read data rd_of(addr).
// ---------------------------------------------------------------------------
module tb_panel_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int EW = 32;

    localparam logic [2:0] K_MEM  = 3'd1;
    localparam logic [2:0] K_DONE = 3'd2;
    localparam logic [2:0] K_DISP = 3'd3;
    localparam logic [2:0] K_RUN  = 3'd4;
    localparam logic [2:0] K_STEP = 3'd5;
    localparam logic [2:0] K_STOP = 3'd6;

    // button vector bit order: load, look, step, run, stop
    localparam logic [4:0] M_LOAD = 5'b00001;
    localparam logic [4:0] M_LOOK = 5'b00010;
    localparam logic [4:0] M_STEP = 5'b00100;
    localparam logic [4:0] M_RUN  = 5'b01000;
    localparam logic [4:0] M_STOP = 5'b10000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic [4:0]    btn;
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_data;
    logic          core_running;
    logic          core_run_o, core_step_o, core_stop_o, pc_wen_o;
    logic [AW-1:0] pc_o;
    logic          mem_val_o, mem_wen_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic [AW-1:0] disp_addr_o;
    logic [DW-1:0] disp_data_o;
    logic          led_inwait_o, led_ready_o;

    panel_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .btn_load_i     (btn[0]),
        .btn_look_i     (btn[1]),
        .btn_step_i     (btn[2]),
        .btn_run_i      (btn[3]),
        .btn_stop_i     (btn[4]),
        .sw_addr_i      (sw_addr),
        .sw_data_i      (sw_data),
        .core_running_i (core_running),
        .core_run_o     (core_run_o),
        .core_step_o    (core_step_o),
        .core_stop_o    (core_stop_o),
        .pc_wen_o       (pc_wen_o),
        .pc_o           (pc_o),
        .mem_val_o      (mem_val_o),
        .mem_wen_o      (mem_wen_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata),
        .mem_rdy_i      (mem_rdy),
        .disp_addr_o    (disp_addr_o),
        .disp_data_o    (disp_data_o),
        .led_inwait_o   (led_inwait_o),
        .led_ready_o    (led_ready_o)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int rdy_lat = 0;

    function automatic logic [EW-1:0] ev(input logic [2:0] k, input logic f,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                                         input logic [3:0] x);
        return {k, f, a, d, x};
    endfunction

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    task automatic check_ev(input logic [EW-1:0] got);
        logic [EW-1:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event got=%h exp=none", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL scoreboard got=%h exp=%h", got, e);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic       prev_val;
    logic [3:0] val_cnt;
    initial begin
        prev_val = 1'b0;
        val_cnt  = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_val = 1'b0;
            end else begin
                if (mem_val_o) begin
                    if (!prev_val) begin
                        val_cnt = 4'd1;
                        check_ev(ev(K_MEM, mem_wen_o, mem_addr_o,
                                    mem_wen_o ? mem_wdata_o : 16'h0, 4'h0));
                    end else begin
                        val_cnt = val_cnt + 4'd1;
                    end
                end
                prev_val = mem_val_o;
                if (pc_wen_o) begin
                    check_ev(ev(K_DONE, 1'b0, pc_o, disp_data_o, val_cnt));
                    check_ev(ev(K_DISP, 1'b0, disp_addr_o, 16'h0, 4'h0));
                end
                if (core_run_o)  check_ev(ev(K_RUN,  1'b0, 8'h0, 16'h0, 4'h0));
                if (core_step_o) check_ev(ev(K_STEP, 1'b0, 8'h0, 16'h0, 4'h0));
                if (core_stop_o) check_ev(ev(K_STOP, 1'b0, 8'h0, 16'h0, 4'h0));
            end
        end
    end

    // ---------------- memory responder ----------------
    int wcnt;
    initial begin
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni || mem_rdy) begin
                mem_rdy = 1'b0;
                wcnt    = 0;
            end else if (mem_val_o) begin
                if (wcnt == rdy_lat) begin
                    mem_rdy   = 1'b1;
                    mem_rdata = rd_of(mem_addr_o);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press(input logic [4:0] mask, input int hold);
        @(negedge clk);
        btn = mask;
        repeat (hold) @(negedge clk);
        btn = '0;
        repeat (14) @(negedge clk);
    endtask

    task automatic push_access(input logic wen, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [3:0] vcnt);
        exp_q.push_back(ev(K_MEM, wen, a, wen ? d : 16'h0, 4'h0));
        exp_q.push_back(ev(K_DONE, 1'b0, a, d, vcnt));
        exp_q.push_back(ev(K_DISP, 1'b0, a, 16'h0, 4'h0));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rst_ni       = 1'b0;
        btn          = '0;
        sw_addr      = '0;
        sw_data      = '0;
        core_running = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_mem_val", 32'(mem_val_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);
        check_val("reset_led_ready", 32'(led_ready_o), 32'h1);
        check_val("reset_led_inwait", 32'(led_inwait_o), 32'h0);
        check_val("reset_disp_addr", 32'(disp_addr_o), 32'h0);
        check_val("reset_disp_data", 32'(disp_data_o), 32'h0);
        check_val("reset_pulses", 32'({core_run_o, core_step_o, core_stop_o, pc_wen_o}), 32'h0);

        // Short glitches (3 high, 1 low, 3 high) must not debounce.
        sw_addr = 8'h10;
        sw_data = 16'hBEEF;
        @(negedge clk);
        btn = M_LOAD;
        repeat (3) @(negedge clk);
        btn = '0;
        @(negedge clk);
        btn = M_LOAD;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (14) @(negedge clk);

        // Proper load, ready after 3 cycles of valid.
        rdy_lat = 2;
        push_access(1'b1, 8'h10, 16'hBEEF, 4'd3);
        press(M_LOAD, 6);
        wait_drain();

        // Auto-increment wraps 0xFF -> 0x00; changed switches restart.
        rdy_lat = 0;
        sw_addr = 8'hFF;
        push_access(1'b0, 8'hFF, 16'hA500, 4'd1);
        press(M_LOOK, 6);
        push_access(1'b0, 8'h00, 16'h5AFF, 4'd1);
        press(M_LOOK, 6);
        sw_addr = 8'h20;
        push_access(1'b0, 8'h20, 16'h7ADF, 4'd1);
        press(M_LOOK, 6);
        rdy_lat = 1;
        sw_data = 16'h1234;
        push_access(1'b1, 8'h21, 16'h1234, 4'd2);
        press(M_LOAD, 6);
        wait_drain();
        check_val("idle_disp_addr", 32'(disp_addr_o), 32'h21);

        // Core running: only stop is honoured.
        core_running = 1'b1;
        @(negedge clk);
        check_val("running_led_ready", 32'(led_ready_o), 32'h0);
        press(M_LOAD, 6);
        press(M_STEP, 6);
        press(M_RUN, 6);
        exp_q.push_back(ev(K_STOP, 1'b0, 8'h0, 16'h0, 4'h0));
        press(M_STOP, 6);
        wait_drain();
        core_running = 1'b0;
        @(negedge clk);

        // Core idle: stop ignored, run beats step, step alone works.
        press(M_STOP, 6);
        exp_q.push_back(ev(K_RUN, 1'b0, 8'h0, 16'h0, 4'h0));
        press(M_RUN | M_STEP, 6);
        exp_q.push_back(ev(K_STEP, 1'b0, 8'h0, 16'h0, 4'h0));
        press(M_STEP, 6);
        wait_drain();

        // Reset in the middle of a request aborts it.
        rdy_lat = 20;
        sw_addr = 8'h40;
        exp_q.push_back(ev(K_MEM, 1'b0, 8'h40, 16'h0, 4'h0));
        @(negedge clk);
        btn = M_LOOK;
        t = 0;
        while (!led_inwait_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_val("reset_test_inwait", 32'(led_inwait_o), 32'h1);
        btn = '0;
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check_val("async_reset_mem_val", 32'(mem_val_o), 32'h0);
        check_val("async_reset_inwait", 32'(led_inwait_o), 32'h0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check_val("post_reset_led_ready", 32'(led_ready_o), 32'h1);
        check_val("post_reset_disp_data", 32'(disp_data_o), 32'h0);
        check_val("post_reset_disp_addr", 32'(disp_addr_o), 32'h0);

        // History is gone after reset: same switches give 0x40, not 0x41.
        rdy_lat = 0;
        push_access(1'b0, 8'h40, 16'h1ABF, 4'd1);
        press(M_LOOK, 6);
        wait_drain();
        repeat (5) @(negedge clk);

        while (exp_q.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing_event got=none exp=%h", e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
